// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two issue-slot request/response channels and
// the single-port data memory bus seen by dmem_arbiter.
//   slave  : the arbiter side
//   master : the core + memory side (drives requests and mem_rdata)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12
);
  // slot requests
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  // slot responses and pipeline control
  logic              done0;
  logic              done1;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;
  logic              err0;
  logic              err1;
  logic              stall;
  logic              ovf;
  // memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output done0, done1, rdata0, rdata1, err0, err1, stall, ovf,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  done0, done1, rdata0, rdata1, err0, err1, stall, ovf,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the two ALU issue
// slots. Accesses of a packet run in program order (slot 0 first); stall
// holds fetch/issue until the last access of the packet completes.
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN
//   defined   : a misaligned slot skips the memory and completes with err=1
//   undefined : addr[1:0] is dropped and err0/err1 stay 0
module dmem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input logic           clk,
  input logic           rs,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  function automatic logic misaligned(input logic [1:0] lo);
    return (lo != 2'b00);
  endfunction
`else
  // Low address bits are dropped in this build; nothing is ever flagged.
  function automatic logic misaligned(input logic [1:0] lo);
    return 1'b0 & (^lo);
  endfunction
`endif

  state_t            state_r;
  state_t            state_nx_s;
  logic              sel_r;
  logic              sel_nx_s;
  logic [1:0]        pend_r;
  logic [1:0]        pend_nx_s;

  logic              we0_r;
  logic              we1_r;
  logic [ADDR_W-1:0] addr0_r;
  logic [ADDR_W-1:0] addr1_r;
  logic [31:0]       wdata0_r;
  logic [31:0]       wdata1_r;
  logic [2:0]        cnt_r;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              done0_r;
  logic              done1_r;
  logic              err0_r;
  logic              err1_r;
  logic [31:0]       rdata0_r;
  logic [31:0]       rdata1_r;
  logic              ovf_r;

  logic              req_any_s;
  logic              other_pend_s;
  logic              cur_we_s;
  logic              cur_mis_s;
  logic              iss_we_s;
  logic              iss_mis_s;
  logic [ADDR_W-1:0] iss_addr_s;
  logic [31:0]       iss_wdata_s;
  logic              stall_s;
  logic              rdata_cap_s;

  assign req_any_s    = bus.req0 | bus.req1;
  assign other_pend_s = sel_r ? pend_r[0] : pend_r[1];
  assign cur_we_s     = sel_r ? we1_r : we0_r;
  assign cur_mis_s    = sel_r ? misaligned(addr1_r[1:0]) : misaligned(addr0_r[1:0]);
  assign rdata_cap_s  = (state_r == WAIT) && (cnt_r == 3'd1) && !cur_we_s;

  // Next-state, slot selection, pend bookkeeping and stall.
  always_comb begin
    state_nx_s = state_r;
    sel_nx_s   = sel_r;
    pend_nx_s  = pend_r;
    stall_s    = 1'b0;
    case (state_r)
      IDLE: begin
        stall_s = 1'b0;
        if (req_any_s) begin
          pend_nx_s  = {bus.req1, bus.req0};
          sel_nx_s   = ~bus.req0;
          state_nx_s = ISSUE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        stall_s = 1'b1;
        if (cur_mis_s) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = WAIT;
        end
      end
      WAIT: begin
        stall_s = 1'b1;
        if (cnt_r == 3'd1) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = WAIT;
        end
      end
      RESP: begin
        pend_nx_s[sel_r] = 1'b0;
        if (other_pend_s) begin
          stall_s    = 1'b1;
          sel_nx_s   = ~sel_r;
          state_nx_s = ISSUE;
        end else begin
          stall_s    = 1'b0;
          state_nx_s = IDLE;
        end
      end
      default: begin
        stall_s    = 1'b0;
        state_nx_s = IDLE;
      end
    endcase
  end

  // Op of the slot about to enter ISSUE: straight from the ports when the
  // packet is arriving, otherwise from the latched copy.
  always_comb begin
    iss_we_s    = we0_r;
    iss_addr_s  = addr0_r;
    iss_wdata_s = wdata0_r;
    if (state_r == IDLE) begin
      if (sel_nx_s) begin
        iss_we_s    = bus.we1;
        iss_addr_s  = bus.addr1;
        iss_wdata_s = bus.wdata1;
      end else begin
        iss_we_s    = bus.we0;
        iss_addr_s  = bus.addr0;
        iss_wdata_s = bus.wdata0;
      end
    end else begin
      if (sel_nx_s) begin
        iss_we_s    = we1_r;
        iss_addr_s  = addr1_r;
        iss_wdata_s = wdata1_r;
      end else begin
        iss_we_s    = we0_r;
        iss_addr_s  = addr0_r;
        iss_wdata_s = wdata0_r;
      end
    end
  end

  assign iss_mis_s = misaligned(iss_addr_s[1:0]);

  // State register, current slot and pending flags.
  always_ff @(posedge clk) begin
    if (rs) begin
      state_r <= IDLE;
      sel_r   <= 1'b0;
      pend_r  <= 2'b00;
    end else begin
      state_r <= state_nx_s;
      sel_r   <= sel_nx_s;
      pend_r  <= pend_nx_s;
    end
  end

  // Latch both slots' op fields when a packet is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rs) begin
      we0_r    <= 1'b0;
      we1_r    <= 1'b0;
      addr0_r  <= '0;
      addr1_r  <= '0;
      wdata0_r <= 32'h0000_0000;
      wdata1_r <= 32'h0000_0000;
    end else if ((state_r == IDLE) && req_any_s) begin
      we0_r    <= bus.we0;
      we1_r    <= bus.we1;
      addr0_r  <= bus.addr0;
      addr1_r  <= bus.addr1;
      wdata0_r <= bus.wdata0;
      wdata1_r <= bus.wdata1;
    end
  end

  // Memory strobe: registered so it is high exactly during ISSUE, and
  // suppressed for a slot that is not sent to memory.
  always_ff @(posedge clk) begin
    if (rs) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      mem_en_r <= (state_nx_s == ISSUE) && !iss_mis_s;
      mem_we_r <= (state_nx_s == ISSUE) && !iss_mis_s && iss_we_s;
      if (state_nx_s == ISSUE) begin
        mem_addr_r  <= {iss_addr_s[ADDR_W-1:2], 2'b00};
        mem_wdata_r <= iss_wdata_s;
      end
    end
  end

  // Latency counter: loaded in ISSUE, counts down through WAIT.
  always_ff @(posedge clk) begin
    if (rs) begin
      cnt_r <= 3'd0;
    end else if (state_r == ISSUE) begin
      cnt_r <= 3'(MEM_LAT);
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r - 3'd1;
    end
  end

  // Per-slot responses: done/err pulse in RESP, load data captured the
  // cycle mem_rdata is valid and held until that slot's next load.
  always_ff @(posedge clk) begin
    if (rs) begin
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
      rdata0_r <= 32'h0000_0000;
      rdata1_r <= 32'h0000_0000;
    end else begin
      done0_r <= (state_nx_s == RESP) && !sel_r;
      done1_r <= (state_nx_s == RESP) && sel_r;
      err0_r  <= (state_nx_s == RESP) && !sel_r && cur_mis_s;
      err1_r  <= (state_nx_s == RESP) && sel_r && cur_mis_s;
      if (rdata_cap_s && !sel_r) begin
        rdata0_r <= bus.mem_rdata;
      end
      if (rdata_cap_s && sel_r) begin
        rdata1_r <= bus.mem_rdata;
      end
    end
  end

  // Sticky overflow: a request arrived while a packet was in flight.
  always_ff @(posedge clk) begin
    if (rs) begin
      ovf_r <= 1'b0;
    end else if ((state_r != IDLE) && req_any_s) begin
      ovf_r <= 1'b1;
    end
  end

  assign bus.stall     = stall_s;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.done0     = done0_r;
  assign bus.done1     = done1_r;
  assign bus.err0      = err0_r;
  assign bus.err1      = err1_r;
  assign bus.rdata0    = rdata0_r;
  assign bus.rdata1    = rdata1_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed packets against a cycle-timeline
// reference model. Stimulus pushes expected responses / memory accesses into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;
  localparam int ADDR_W = 12;
  localparam int LAT    = 2;
  localparam int NEVER  = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rs  = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) dut (
    .clk (clk),
    .rs  (rs),
    .bus (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // power-up memory content; word 4 (byte 0x010) holds 0xDEADBEEF
  function automatic logic [31:0] init_val(input int w);
    logic [31:0] v;
    v = 32'(w) * 32'h9E37_79B9;
    return (w == 4) ? 32'hDEAD_BEEF : (v ^ 32'h5A5A_0000);
  endfunction

  // ---------------- memory environment (L-cycle read pipe) -------------
  logic [31:0] mem_arr [1024];
  bit          written [1024];
  logic [31:0] pipe    [LAT];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem_arr[bus.mem_addr[11:2]] <= bus.mem_wdata;
        written[bus.mem_addr[11:2]] <= 1'b1;
      end
      pipe[0] <= written[bus.mem_addr[11:2]] ? mem_arr[bus.mem_addr[11:2]]
                                             : init_val(int'(bus.mem_addr[11:2]));
    end else begin
      pipe[0] <= $urandom;
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  // ---------------- reference model + scoreboard -----------------------
  typedef struct { int cyc; int slot; logic [31:0] rd; logic err; } done_t;
  typedef struct { int cyc; logic we; logic [ADDR_W-1:0] addr; logic [31:0] wd; } acc_t;

  done_t       dq [$];
  acc_t        aq [$];
  logic [31:0] ref_mem [int];
  logic [31:0] prev_rd [2];
  logic [31:0] hold_rd [2];
  int          busy_lo = 0;
  int          busy_hi = 0;
  int          ovf_from = NEVER;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  // One slot's turn starting at cycle t; returns the first cycle of the next turn.
  task automatic model_slot(input int s, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [31:0] d, input int t, output int tn);
    done_t e;
    acc_t  m;
    int    w;
    bit    mis;
    w = int'(a) / 4;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    mis = (int'(a) % 4) != 0;
`else
    mis = 1'b0;
`endif
    if (mis) begin
      e = '{t + 1, s, prev_rd[s], 1'b1};
    end else begin
      m = '{t, we, ADDR_W'(w * 4), d};
      aq.push_back(m);
      if (we) ref_mem[w] = d;
      else    prev_rd[s] = ref_rd(w);
      e = '{t + 1 + LAT, s, prev_rd[s], 1'b0};
    end
    dq.push_back(e);
    tn = e.cyc + 1;
  endtask

  task automatic issue(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [ADDR_W-1:0] a1, input logic [31:0] d1);
    int t;
    while (cyc <= busy_hi) step();
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    t = cyc + 1;
    busy_lo = cyc + 1;
    if (r0) model_slot(0, w0, a0, d0, t, t);
    if (r1) model_slot(1, w1, a1, d1, t, t);
    busy_hi = t - 1;
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int w;
    int lo;
    w  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 7);
    lo = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
    return ADDR_W'(w * 4 + lo);
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mem_en"}, bus.mem_en, 1'b0);
    chk({tag, "_stall"},  bus.stall,  1'b0);
    chk({tag, "_done"},   {bus.done1, bus.done0}, 2'b00);
    chk({tag, "_rdata0"}, bus.rdata0, 32'h0);
    chk({tag, "_rdata1"}, bus.rdata1, 32'h0);
    chk({tag, "_ovf"},    bus.ovf,    1'b0);
    chk({tag, "_err"},    {bus.err1, bus.err0}, 2'b00);
  endtask

  // ---------------- monitor --------------------------------------------
  task automatic check_done(input int s, input logic [31:0] rd, input logic er);
    done_t e;
    if (dq.size() == 0) begin
      chk("done_unexpected", 64'(s), 64'(NEVER));
    end else begin
      e = dq.pop_front();
      chk("done_cycle", 64'(cyc), 64'(e.cyc));
      chk("done_slot",  64'(s),   64'(e.slot));
      chk("rdata",      rd,       e.rd);
      chk("err",        er,       e.err);
      hold_rd[s] = e.rd;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (dq.size() > 0 && dq[0].cyc < cyc) begin
        chk("done_missing_at", 64'(NEVER), 64'(dq[0].cyc));
        dq.delete(0);
      end
      if (aq.size() > 0 && aq[0].cyc < cyc) begin
        chk("mem_en_missing_at", 64'(NEVER), 64'(aq[0].cyc));
        aq.delete(0);
      end
      chk("stall", bus.stall, (cyc >= busy_lo) && (cyc < busy_hi));
      chk("ovf",   bus.ovf,   cyc >= ovf_from);
      if (bus.done0) check_done(0, bus.rdata0, bus.err0);
      else           chk("rdata0_hold", bus.rdata0, hold_rd[0]);
      if (bus.done1) check_done(1, bus.rdata1, bus.err1);
      else           chk("rdata1_hold", bus.rdata1, hold_rd[1]);
      if (bus.mem_en) begin
        if (aq.size() == 0) begin
          chk("mem_en_unexpected", 64'(bus.mem_addr), 64'(NEVER));
        end else begin
          acc_t m;
          m = aq.pop_front();
          chk("mem_cycle", 64'(cyc), 64'(m.cyc));
          chk("mem_we",    bus.mem_we,   m.we);
          chk("mem_addr",  bus.mem_addr, m.addr);
          if (m.we) chk("mem_wdata", bus.mem_wdata, m.wd);
        end
      end
    end
  end

  // ---------------- stimulus -------------------------------------------
  initial begin
    logic r0, r1, w0, w1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
    prev_rd[0] = 32'h0; prev_rd[1] = 32'h0;
    hold_rd[0] = 32'h0; hold_rd[1] = 32'h0;

    repeat (3) step();
    rs = 1'b0;
    chk_reset_state("por");
    mon_en = 1'b1;

    // single lw of 0xDEADBEEF at 0x010
    issue(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    // dual packet: slot0 sw then slot1 lw of the same word
    issue(1'b1, 1'b1, 12'h020, 32'h1234_5678, 1'b1, 1'b0, 12'h020, 32'h0);
    // slot-1-only lw
    issue(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
    // misaligned lw on slot 0, and a misaligned sw on slot 1 after it
    issue(1'b1, 1'b0, 12'h013, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    issue(1'b1, 1'b0, 12'h024, 32'h0, 1'b1, 1'b1, 12'h016, 32'hCAFE_F00D);

    // randomized packets, gaps of 0..2 idle cycles
    for (int k = 0; k < 150; k++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) step();
      issue(r0, w0, rand_addr(), $urandom, r1, w1, rand_addr(), $urandom);
    end

    // overflow: requests pulsed during WAIT are ignored, ovf sticks
    issue(1'b1, 1'b0, 12'h040, 32'h0, 1'b1, 1'b0, 12'h044, 32'h0);
    step();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 12'h044; bus.wdata0 = 32'hBAD0_BAD0;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h048; bus.wdata1 = 32'hBAD1_BAD1;
    ovf_from = cyc + 1;
    step();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    issue(1'b1, 1'b0, 12'h044, 32'h0, 1'b1, 1'b0, 12'h048, 32'h0);

    // reset held for 2 cycles during WAIT of an in-flight load
    issue(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    step();
    mon_en = 1'b0;
    rs = 1'b1;
    step();
    step();
    rs = 1'b0;
    dq.delete();
    aq.delete();
    prev_rd[0] = 32'h0; prev_rd[1] = 32'h0;
    hold_rd[0] = 32'h0; hold_rd[1] = 32'h0;
    ovf_from = NEVER;
    busy_lo = 0;
    busy_hi = 0;
    chk_reset_state("rst");
    mon_en = 1'b1;
    issue(1'b1, 1'b0, 12'h024, 32'h0, 1'b1, 1'b0, 12'h010, 32'h0);

    while (cyc <= busy_hi + 2) step();
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    chk("mem_queue_empty",  64'(aq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the two ALU issue slots of the dual-issue core. Slot 0 is the older instruction of a packet and slot 1 the younger. Both slots can present a lw/sw in the same issue packet. The block serializes the accesses in program order (slot 0 first), holds the pipeline with `stall` until the packet's accesses complete, and returns load data per slot.

## Interface
Parameters:
- `ADDR_W`, 12: byte address width; the memory is 4096 bytes.
- `MEM_LAT`, 1: cycles from `mem_en` to valid `mem_rdata`; range 1..7.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rs` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: single-cycle pulse, slot has a memory op in the issued packet.
- `we0` / `we1` in 1: 1 = sw, 0 = lw; sampled with req.
- `addr0` / `addr1` in `ADDR_W`: byte address; sampled with req.
- `wdata0` / `wdata1` in 32: store data; sampled with req.
- `done0` / `done1` out 1: one-cycle pulse, slot access complete.
- `rdata0` / `rdata1` out 32: load result; valid with done, held until the next load on that slot.
- `err0` / `err1` out 1: valid with done; 1 = misaligned (see Configuration).
- `stall` out 1: freeze fetch/issue.
- `ovf` out 1: sticky; a req arrived while busy. Cleared only by `rs`.
- `mem_en` out 1: registered memory strobe.
- `mem_we` out 1: registered write enable.
- `mem_addr` out `ADDR_W`: registered address; word-aligned, bits [1:0] = 0.
- `mem_wdata` out 32: registered write data.
- `mem_rdata` in 32: memory read data.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Either req latches the op fields for both slots and sets `pend0`/`pend1`.
  - Go to ISSUE for the lowest pending slot.
- ISSUE (1 cycle):
  - Drive `mem_en=1` with the selected slot's we/addr/wdata.
  - Load latency counter with `MEM_LAT`.
  - Go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle `mem_rdata` is valid (counter reaches 1), capture it into the slot's result register if the op is a load.
  - Go to RESP.
- RESP (1 cycle):
  - Pulse the slot's `done`.
  - Clear its pend flag.
  - If the other slot is still pending, go to ISSUE for it; otherwise go to IDLE.
- Program order:
  - slot 0 always completes before slot 1 is issued.
  - A slot-1 lw to the same word as a slot-0 sw returns the stored value.
- sw completes with done; its `rdata` is unchanged.
- A req while not in IDLE is ignored: no latch, `ovf` is set.
- Reset (any state, including mid-access):
  - state = IDLE, pend flags = 0, `mem_en` = 0 on the next cycle.
  - All outputs = 0, including `rdata0`/`rdata1`, `ovf` and the err bits.

## Timing
L = `MEM_LAT`; T is the req cycle.
- Single access, slot s:
  - `mem_en`: T+1.
  - `mem_rdata` sampled: T+1+L.
  - `done_s` and `rdata_s`: T+2+L.
- Both slots:
  - `done0`: T+2+L.
  - slot-1 `mem_en`: T+3+L.
  - `done1`: T+4+2L.
- `stall`:
  - Combinational: 1 when state is not IDLE, except in the RESP cycle of the last pending slot.
  - For a single access it is high T+1 .. T+1+L.
  - The pipeline advances in the final done cycle.
- A new req is legal in the cycle after the final done. Back-to-back packets have no bubble beyond this.
- `mem_en` is never high in two consecutive cycles.

## Configuration
- Macro: `DMEM_ARB_ALIGN_CHK_EN`.
- Defined:
  - A slot whose `addr[1:0] != 0` is not sent to memory.
  - That slot skips ISSUE/WAIT and goes straight to RESP, giving done one cycle after its turn begins, with `err=1`.
  - `rdata` and memory are untouched.
- Undefined:
  - `addr[1:0]` is silently forced to 0.
  - `err0`/`err1` are tied 0.

## Test plan
- Reset, L=1:
  - Assert `rs` for 2 cycles during a WAIT.
  - Next cycle: `mem_en=0`, `stall=0`, `done*=0`, `rdata*=0`; state IDLE.
- Single lw, L=2:
  - mem holds 0xDEADBEEF at 0x010.
  - `req0`, `we0=0`, `addr0=0x010` at T.
  - `mem_en` and `mem_addr=0x010` at T+1.
  - `done0=1`, `rdata0=0xDEADBEEF` at T+4.
  - `stall` high T+1..T+3.
- Dual packet, L=1:
  - slot 0 sw 0x12345678 to 0x020; slot 1 lw 0x020, same cycle T.
  - `done0` at T+3.
  - slot-1 `mem_en` at T+4.
  - `done1` at T+6 with `rdata1=0x12345678`.
- Slot-1-only lw, L=1:
  - `req1` only at T.
  - `done1` at T+3; `done0` never asserts.
- Overflow: `req0` pulsed during WAIT. Required:
  - ignored, `ovf=1` and stays 1.
  - In-flight access completes normally.
- Alignment (both builds), `addr0=0x013` lw:
  - Defined: no `mem_en`, `done0`+`err0` at T+2.
  - Undefined: `mem_addr=0x010`, `err0=0`.
